// File: rtl/swipt_guard_pkg.sv
// -----------------------------------------------------------------------------
// swipt_guard_pkg
// Shared types and default constants for the SWIPT heartbeat guard.
//   guard_state_e : FSM encoding exposed on the 'state' port of the guard
//   fault_code_e  : latched fault reason exposed on 'fault_code'
//   DEF_*         : default parameter values used by the guard modules
// -----------------------------------------------------------------------------
package swipt_guard_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMING = 2'd1,
    ST_ARMED  = 2'd2,
    ST_FAULT  = 2'd3
  } guard_state_e;

  typedef enum logic [1:0] {
    FLT_NONE    = 2'd0,
    FLT_TIMEOUT = 2'd1,
    FLT_GLITCH  = 2'd2
  } fault_code_e;

  localparam int unsigned DEF_OUT_W          = 4;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1000000;
  localparam int unsigned DEF_MIN_EDGE_GAP   = 16;
  localparam int unsigned DEF_ARM_EDGES      = 4;
  localparam int unsigned DEF_CNT_W          = 24;

  // ARMING and ARMED are the states in which heartbeat faults and an
  // enable drop cause an exit.
  function automatic logic is_live(input guard_state_e s);
    return (s == ST_ARMING) || (s == ST_ARMED);
  endfunction

endpackage

// File: rtl/swipt_hb_edge_monitor.sv
// -----------------------------------------------------------------------------
// swipt_hb_edge_monitor
// Heartbeat edge detector and edge-spacing monitor.
//   Optional macro SWIPT_GUARD_SYNC_EN: inserts a 2-flop synchronizer on the
//   heartbeat input (2 cycles of added latency); otherwise the heartbeat is
//   used directly.
// Ports:
//   i_clk        : system clock
//   i_nrst       : synchronous active-low reset
//   i_heartbeat  : heartbeat toggle from the processing system
//   o_edge       : any heartbeat transition this cycle
//   o_valid_edge : transition with acceptable spacing (or the first one)
//   o_glitch     : transition closer than MIN_EDGE_GAP cycles
//   o_timeout    : no transition and gap has reached TIMEOUT_CYCLES
//   o_gap        : cycles since last transition, saturating
// -----------------------------------------------------------------------------
module swipt_hb_edge_monitor #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned MIN_EDGE_GAP   = 16,
  parameter int unsigned CNT_W          = 24
) (
  input  logic             i_clk,
  input  logic             i_nrst,
  input  logic             i_heartbeat,
  output logic             o_edge,
  output logic             o_valid_edge,
  output logic             o_glitch,
  output logic             o_timeout,
  output logic [CNT_W-1:0] o_gap
);

  localparam logic [CNT_W-1:0] L_TIMEOUT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] L_MIN_GAP = CNT_W'(MIN_EDGE_GAP);

  logic             w_hb_s;
  logic             w_edge;
  logic             r_hb_q;
  logic [CNT_W-1:0] r_gap_cnt;
  logic             r_first_edge;

`ifdef SWIPT_GUARD_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_heartbeat;
      r_sync2 <= r_sync1;
    end
  end

  assign w_hb_s = r_sync2;
`else
  assign w_hb_s = i_heartbeat;
`endif

  assign w_edge = w_hb_s ^ r_hb_q;

  // hb_q tracks hb_s even in reset so release never produces a false edge.
  always_ff @(posedge i_clk) begin
    r_hb_q <= w_hb_s;
    if (!i_nrst) begin
      r_gap_cnt    <= '0;
      r_first_edge <= 1'b1;
    end else if (w_edge) begin
      r_gap_cnt    <= '0;
      r_first_edge <= 1'b0;
    end else if (r_gap_cnt < L_TIMEOUT) begin
      r_gap_cnt <= r_gap_cnt + CNT_W'(1);
    end
  end

  // An edge arriving exactly at the timeout boundary is a valid edge.
  assign o_edge       = w_edge;
  assign o_valid_edge = w_edge && (r_first_edge || (r_gap_cnt >= L_MIN_GAP));
  assign o_glitch     = w_edge && !o_valid_edge;
  assign o_timeout    = !w_edge && (r_gap_cnt >= L_TIMEOUT);
  assign o_gap        = r_gap_cnt;

endmodule

// File: rtl/swipt_heartbeat_guard.sv
// -----------------------------------------------------------------------------
// swipt_heartbeat_guard
// Safety gate between the SWIPT PWM generator and the SWIPT_OUT pins. The
// drive bus passes (registered) only while ARMED; arming needs ARM_EDGES
// clean heartbeat edges, and timeout/glitch faults latch until cleared.
//   Optional macro SWIPT_GUARD_SYNC_EN: synchronize heartbeat_in (see
//   swipt_hb_edge_monitor).
// Ports:
//   clk, nrst      : clock, synchronous active-low reset
//   heartbeat_in   : heartbeat toggle from the processing system
//   enable_req     : drive request from the frequency tracker
//   out_req        : raw PWM drive (OUT_W)
//   clear_fault    : fault acknowledge
//   out_gated      : gated drive to SWIPT_OUT (OUT_W, registered)
//   swipt_alive    : set on any edge, cleared on timeout
//   state          : 0 IDLE, 1 ARMING, 2 ARMED, 3 FAULT
//   fault_code     : 0 none, 1 timeout, 2 glitch
//   db_edge_count  : wrapping count of valid edges
//   db_gap         : current gap counter
// -----------------------------------------------------------------------------
module swipt_heartbeat_guard
  import swipt_guard_pkg::*;
#(
  parameter int unsigned OUT_W          = DEF_OUT_W,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned MIN_EDGE_GAP   = DEF_MIN_EDGE_GAP,
  parameter int unsigned ARM_EDGES      = DEF_ARM_EDGES,
  parameter int unsigned CNT_W          = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             heartbeat_in,
  input  logic             enable_req,
  input  logic [OUT_W-1:0] out_req,
  input  logic             clear_fault,
  output logic [OUT_W-1:0] out_gated,
  output logic             swipt_alive,
  output logic [1:0]       state,
  output logic [1:0]       fault_code,
  output logic [31:0]      db_edge_count,
  output logic [CNT_W-1:0] db_gap
);

  localparam logic [7:0] L_ARM_EDGES = 8'(ARM_EDGES);

  logic w_edge;
  logic w_valid_edge;
  logic w_glitch;
  logic w_timeout;

  guard_state_e     r_state;
  guard_state_e     w_state_nxt;
  fault_code_e      r_fault;
  fault_code_e      w_fault_nxt;
  logic [7:0]       r_arm_cnt;
  logic [7:0]       w_arm_cnt_nxt;
  logic             w_exit;
  logic [OUT_W-1:0] w_out_nxt;
  logic [OUT_W-1:0] r_out_gated;
  logic             r_alive;
  logic [31:0]      r_edge_count;

  swipt_hb_edge_monitor #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .MIN_EDGE_GAP   (MIN_EDGE_GAP),
    .CNT_W          (CNT_W)
  ) u_mon (
    .i_clk        (clk),
    .i_nrst       (nrst),
    .i_heartbeat  (heartbeat_in),
    .o_edge       (w_edge),
    .o_valid_edge (w_valid_edge),
    .o_glitch     (w_glitch),
    .o_timeout    (w_timeout),
    .o_gap        (db_gap)
  );

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state <= ST_IDLE;
      r_fault <= FLT_NONE;
      r_arm_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_fault <= w_fault_nxt;
      r_arm_cnt <= w_arm_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_fault_nxt   = r_fault;
    w_arm_cnt_nxt = r_arm_cnt;
    w_exit        = is_live(r_state) && (w_timeout || w_glitch || !enable_req);

    case (r_state)
      ST_IDLE: begin
        if (enable_req) begin
          w_state_nxt   = ST_ARMING;
          w_arm_cnt_nxt = '0;
        end
      end
      ST_ARMING, ST_ARMED: begin
        // Faults outrank an enable drop seen in the same cycle.
        if (w_timeout) begin
          w_state_nxt = ST_FAULT;
          w_fault_nxt = FLT_TIMEOUT;
        end else if (w_glitch) begin
          w_state_nxt = ST_FAULT;
          w_fault_nxt = FLT_GLITCH;
        end else if (!enable_req) begin
          w_state_nxt = ST_IDLE;
        end else if ((r_state == ST_ARMING) && w_valid_edge) begin
          w_arm_cnt_nxt = r_arm_cnt + 8'd1;
          if ((r_arm_cnt + 8'd1) == L_ARM_EDGES) begin
            w_state_nxt = ST_ARMED;
          end
        end
      end
      ST_FAULT: begin
        if (clear_fault && !enable_req) begin
          w_state_nxt = ST_IDLE;
          w_fault_nxt = FLT_NONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_fault_nxt = FLT_NONE;
      end
    endcase

    // Same-cycle gating: drive is cut on the edge after an exit is seen.
    w_out_nxt = ((r_state == ST_ARMED) && !w_exit) ? out_req : '0;
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_out_gated  <= '0;
      r_alive      <= 1'b0;
      r_edge_count <= '0;
    end else begin
      r_out_gated <= w_out_nxt;
      if (w_edge) begin
        r_alive <= 1'b1;
      end else if (w_timeout) begin
        r_alive <= 1'b0;
      end
      if (w_valid_edge) begin
        r_edge_count <= r_edge_count + 32'd1;
      end
    end
  end

  assign out_gated     = r_out_gated;
  assign swipt_alive   = r_alive;
  assign state         = r_state;
  assign fault_code    = r_fault;
  assign db_edge_count = r_edge_count;

endmodule

// File: doc/swipt_heartbeat_guard.md
# swipt_heartbeat_guard

Parametrised safety gate between the SWIPT PWM generator and the SWIPT_OUT pins, generalising the heartbeat watchdog in the SWIPT top level. It watches the heartbeat toggle from the processing system and enforces a minimum and maximum edge spacing. It arms only after a configurable number of clean heartbeat edges. While armed it passes an OUT_W-wide drive bus through a register; otherwise it forces the bus to zero, and it latches a fault code until software clears it.

## Interface
- OUT_W, 4: number of gated drive lines.
- TIMEOUT_CYCLES, 1000000: maximum cycles between heartbeat edges.
- MIN_EDGE_GAP, 16: minimum cycles between edges; closer edges are a glitch.
- ARM_EDGES, 4: clean edges required to arm, range 1..255.
- CNT_W, 24: gap counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; the block has one clock.
- nrst  in  1  reset, synchronous, active-low.
- heartbeat_in  in  1  heartbeat toggle (swiptONHeartbeat).
- enable_req  in  1  request to drive, from the frequency tracker enable.
- out_req  in  OUT_W  raw PWM drive.
- clear_fault  in  1  fault acknowledge.
- out_gated  out  OUT_W  gated drive to the SWIPT_OUT pins.
- swipt_alive  out  1  legacy-compatible liveness flag.
- state  out  2  0 IDLE, 1 ARMING, 2 ARMED, 3 FAULT.
- fault_code  out  2  0 none, 1 TIMEOUT, 2 GLITCH.
- db_edge_count  out  32  valid edges, wrapping.
- db_gap  out  CNT_W  gap counter value.

## Operation
- Edge detect: hb_q holds the previous hb_s value, where hb_s is the heartbeat after the optional synchronizer. edge = hb_s ^ hb_q.
- hb_q loads hb_s during reset, so no spurious edge appears on reset release.
- gap_cnt counts cycles since the last edge and saturates at TIMEOUT_CYCLES. It is cleared on any edge.
- first_edge is set by reset and cleared by the first edge.
- valid edge = edge && (first_edge || gap_cnt >= MIN_EDGE_GAP).
- glitch = edge && !valid edge.
- timeout = !edge && gap_cnt >= TIMEOUT_CYCLES. An edge in the cycle where the gap reaches TIMEOUT_CYCLES counts as a valid edge, not a timeout.
- FSM:
  - IDLE: if enable_req, go to ARMING and set arm_cnt = 0.
  - ARMING: each valid edge increments arm_cnt. When arm_cnt+1 == ARM_EDGES on a valid edge, go to ARMED.
  - ARMED: holds until an exit condition below.
  - FAULT: go to IDLE only when clear_fault && !enable_req; fault_code returns to 0 at the same time.
- Exit conditions in ARMING and ARMED, in priority order:
  - timeout: go to FAULT with code 1.
  - glitch: go to FAULT with code 2.
  - !enable_req: go to IDLE with no fault.
- A fault takes precedence over an enable drop detected in the same cycle.
- In IDLE, glitches and timeouts are ignored; no fault is raised.
- out_gated is registered. It takes out_req only if state == ARMED and no exit condition is present in that cycle; otherwise it is 0.
- swipt_alive is set by any edge and cleared on timeout, independent of the FSM.
- db_edge_count increments on each valid edge.

## Timing
- Reset values:
  - out_gated = 0
  - swipt_alive = 0
  - state = IDLE
  - fault_code = 0
  - db_edge_count = 0
  - db_gap = 0
  - arm_cnt = 0
  - first_edge = 1
- Reset asserted mid-operation forces every register above to its reset value on the next clk edge; out_gated is 0 from that edge.
- out_req to out_gated latency is 1 cycle while ARMED.
- Shutdown: out_gated is 0 on the clk edge after the cycle in which the exit condition is seen.
- state and fault_code update on the same edge as the shutdown.
- With SWIPT_GUARD_SYNC_EN defined, add 2 cycles of heartbeat-to-edge latency.

## Configuration
- SWIPT_GUARD_SYNC_EN defined: heartbeat_in passes through a 2-flop synchronizer to form hb_s. The synchronizer flops reset to 0. Use this setting for asynchronous heartbeat sources.
- Not defined: hb_s = heartbeat_in directly, with zero added latency.

## Structure
- Package swipt_guard_pkg holds:
  - state encodings ST_IDLE, ST_ARMING, ST_ARMED, ST_FAULT (2-bit)
  - fault codes FLT_NONE, FLT_TIMEOUT, FLT_GLITCH
  - default parameter constants.
- Sub-module swipt_hb_edge_monitor contains the synchronizer, edge detect, gap_cnt, first_edge, and the valid/glitch/timeout strobes. The top module holds the FSM, the output register and the debug counters.

## Test plan
- Arming: enable_req = 1, edges every 100 cycles, ARM_EDGES = 4. state goes 1 → 2 after the 4th edge, then out_gated follows out_req = 4'b1010 one cycle late.
- Timeout: armed, then the heartbeat stops. On the cycle gap_cnt hits TIMEOUT_CYCLES (test value 1000), out_gated goes 0 the next edge, state = 3, fault_code = 1, swipt_alive = 0.
- Glitch: armed, then two edges 5 cycles apart with MIN_EDGE_GAP = 16. The result is FAULT with code 2, and out_gated = 0 on the next edge.
- Fault clear: in FAULT, clear_fault = 1 with enable_req = 1 keeps state in FAULT. Dropping enable_req returns state to IDLE with fault_code = 0.
- Boundary: an edge exactly when gap_cnt == TIMEOUT_CYCLES is accepted and the block stays ARMED. An enable_req drop in the same cycle as a glitch yields FAULT code 2.
- Reset mid-ARMED: nrst = 0 for 1 cycle while out_req = 4'hF. out_gated = 0 the next edge, state = IDLE, db_edge_count = 0, and no edge is detected on release.
